audio_clk_monitor: RTL and testbench
====================================

AUDIO_CLK_MONITOR -- requirements
Module: audio_clk_monitor

Interface
REQ-001 Parameter WINDOW_CYCLES, default 50000, sets the measurement window length in clk cycles (1 ms at 50 MHz).
REQ-002 Parameter EXPECTED_COUNT, default 12288, sets the nominal mon_clk rising edges per window.
REQ-003 Parameter TOLERANCE, default 16, sets the maximum allowed |edge_count - EXPECTED_COUNT|.
REQ-004 Parameter GOOD_WINDOWS, default 3, sets the consecutive in-tolerance windows required to assert freq_ok (range 1..15).
REQ-005 Parameter STALL_CYCLES, default 64, sets the clk cycles without a mon_clk edge before clk_lost asserts.
REQ-006 Port clk, input, 1 bit: 50 MHz system clock; the only clock in the block.
REQ-007 Port reset_n, input, 1 bit: reset, synchronous to clk, active-low.
REQ-008 Port mon_clk, input, 1 bit: audio PLL output clock, asynchronous to clk and sampled as data.
REQ-009 Port pll_locked, input, 1 bit: audio PLL lock indication, asynchronous to clk.
REQ-010 Port enable, input, 1 bit: monitor enable, synchronous to clk.
REQ-011 Port irq_clear, input, 1 bit: single-cycle clear of irq.
REQ-012 Port edge_count, output, 16 bits: edge count from the last completed window.
REQ-013 Port count_valid, output, 1 bit: one-cycle pulse when edge_count updates.
REQ-014 Port freq_ok, output, 1 bit: mon_clk frequency is qualified.
REQ-015 Port clk_lost, output, 1 bit: no mon_clk edge seen for STALL_CYCLES cycles.
REQ-016 Port irq, output, 1 bit: sticky fault flag.

Function
REQ-017 mon_clk and pll_locked SHALL each pass through a 2-flop synchronizer; mon_clk SHALL have one further delay flop, and a rising edge is sync=1 with delayed=0.
REQ-018 Latency from a mon_clk rising transition to the edge being counted SHALL be exactly 3 clk cycles.
REQ-019 The FSM SHALL have states IDLE, WAIT_LOCK, MEASURE and EVAL.
REQ-020 IDLE SHALL go to WAIT_LOCK when enable=1, and WAIT_LOCK SHALL go to MEASURE when synced pll_locked=1, clearing the window and edge counters on entry.
REQ-021 MEASURE SHALL count window cycles 0..WINDOW_CYCLES-1, count detected edges saturating at 16'hFFFF, include any edge on the terminal cycle, and then go to EVAL.
REQ-022 EVAL SHALL last one cycle: latch edge_count, pulse count_valid, evaluate tolerance, then return to MEASURE with both counters cleared; an edge during EVAL SHALL be dropped.
REQ-023 In-tolerance (inclusive bound) SHALL increment good_streak, saturating at GOOD_WINDOWS; freq_ok SHALL assert in the EVAL cycle in which good_streak reaches GOOD_WINDOWS.
REQ-024 Out-of-tolerance SHALL clear good_streak and freq_ok, and SHALL set irq if freq_ok was 1.
REQ-025 Synced pll_locked=0 in MEASURE or EVAL SHALL go to WAIT_LOCK, clear good_streak and freq_ok, and set irq if freq_ok was 1; an EVAL update is discarded on that cycle.
REQ-026 enable=0 SHALL force IDLE from any state on the next cycle, clear freq_ok, clk_lost and good_streak, and SHALL NOT change irq or edge_count.
REQ-027 A stall counter SHALL run only in MEASURE, clear on each detected edge, saturate, and assert clk_lost when it reaches STALL_CYCLES.
REQ-028 clk_lost SHALL deassert on the cycle after the next detected edge or on leaving MEASURE/EVAL.
REQ-029 A clk_lost assertion SHALL clear freq_ok and good_streak, and SHALL set irq if freq_ok was 1.
REQ-030 irq SHALL clear on irq_clear=1; if a set and irq_clear occur in the same cycle, the set SHALL win.

Reset
REQ-031 reset_n=0 sampled at a clk edge SHALL put the FSM in IDLE and zero all counters, synchronizers, good_streak, edge_count, count_valid, freq_ok, clk_lost and irq.
REQ-032 Reset asserted mid-window SHALL discard the partial count without a count_valid pulse.

Verification (WINDOW_CYCLES=100, EXPECTED_COUNT=25, TOLERANCE=1, GOOD_WINDOWS=3, STALL_CYCLES=16)
REQ-033 Drive mon_clk with period 4 clk and pll_locked=1, then enable=1 -> count_valid pulses every 101 cycles with edge_count=25, and freq_ok=1 at the 3rd pulse.
REQ-034 Once qualified, switch mon_clk to period 5 -> next edge_count=20, freq_ok=0 and irq=1 in that EVAL cycle.
REQ-035 Once qualified, hold mon_clk at 0 -> clk_lost=1 and irq=1 exactly 16 cycles after the last counted edge; restarting mon_clk deasserts clk_lost.
REQ-036 Once qualified, drop pll_locked for 10 cycles -> FSM in WAIT_LOCK, freq_ok=0, irq=1, and no count_valid until lock returns plus 101 cycles.
REQ-037 Pulse irq_clear in the same cycle as a fault set -> irq stays 1; a later irq_clear pulse with no fault -> irq=0.
REQ-038 Assert reset_n=0 at window cycle 50 -> all outputs 0 on the next cycle and no count_valid for that window.

Source files
------------

// File: rtl/audio_clk_monitor.sv
// Audio PLL clock monitor: counts mon_clk edges over fixed clk windows, qualifies
// the frequency over consecutive good windows and flags stalls and lock loss.
module audio_clk_monitor #(
    parameter int unsigned WINDOW_CYCLES  = 50000,
    parameter int unsigned EXPECTED_COUNT = 12288,
    parameter int unsigned TOLERANCE      = 16,
    parameter int unsigned GOOD_WINDOWS   = 3,
    parameter int unsigned STALL_CYCLES   = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mon_clk,
    input  logic        pll_locked,
    input  logic        enable,
    input  logic        irq_clear,
    output logic [15:0] edge_count,
    output logic        count_valid,
    output logic        freq_ok,
    output logic        clk_lost,
    output logic        irq
);

    localparam int unsigned WIN_W   = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_CYCLES + 1);

    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0]   WIN_ONE   = WIN_W'(1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);
    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
    localparam logic [16:0]        EXP17     = 17'(EXPECTED_COUNT);
    localparam logic [16:0]        TOL17     = 17'(TOLERANCE);
    localparam logic [3:0]         GOOD4     = 4'(GOOD_WINDOWS);

    typedef enum logic [1:0] {IDLE, WAIT_LOCK, MEASURE, EVAL} state_t;

    state_t             state_reg, state_next;
    logic [WIN_W-1:0]   win_cnt_reg, win_cnt_next;
    logic [15:0]        edge_cnt_reg, edge_cnt_next;
    logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic [3:0]         good_streak_reg, good_streak_next;
    logic [15:0]        edge_count_reg, edge_count_next;
    logic               count_valid_reg, count_valid_next;
    logic               freq_ok_reg, freq_ok_next;
    logic               clk_lost_reg, clk_lost_next;
    logic               irq_reg, irq_next;
    logic               mon_dly_reg;

    logic [1:0]  async_in;
    logic [1:0]  synced;
    logic        mon_sync;
    logic        lock_sync;
    logic        mon_edge;
    logic        lock_drop;
    logic        irq_set;
    logic [16:0] cnt17;
    logic [16:0] diff;
    logic        in_tol;

    assign async_in = {pll_locked, mon_clk};

    // Bit 0 carries mon_clk, bit 1 carries pll_locked.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign synced[gi] = sync_reg;
        end
    endgenerate

    assign mon_sync  = synced[0];
    assign lock_sync = synced[1];
    assign mon_edge  = mon_sync & ~mon_dly_reg;

    assign cnt17  = {1'b0, edge_cnt_reg};
    assign diff   = (cnt17 >= EXP17) ? (cnt17 - EXP17) : (EXP17 - cnt17);
    assign in_tol = (diff <= TOL17);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            win_cnt_reg     <= '0;
            edge_cnt_reg    <= '0;
            stall_cnt_reg   <= '0;
            good_streak_reg <= '0;
            edge_count_reg  <= '0;
            count_valid_reg <= 1'b0;
            freq_ok_reg     <= 1'b0;
            clk_lost_reg    <= 1'b0;
            irq_reg         <= 1'b0;
            mon_dly_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            win_cnt_reg     <= win_cnt_next;
            edge_cnt_reg    <= edge_cnt_next;
            stall_cnt_reg   <= stall_cnt_next;
            good_streak_reg <= good_streak_next;
            edge_count_reg  <= edge_count_next;
            count_valid_reg <= count_valid_next;
            freq_ok_reg     <= freq_ok_next;
            clk_lost_reg    <= clk_lost_next;
            irq_reg         <= irq_next;
            mon_dly_reg     <= mon_sync;
        end
    end

    always_comb begin
        state_next       = state_reg;
        win_cnt_next     = win_cnt_reg;
        edge_cnt_next    = edge_cnt_reg;
        stall_cnt_next   = stall_cnt_reg;
        good_streak_next = good_streak_reg;
        edge_count_next  = edge_count_reg;
        count_valid_next = 1'b0;
        freq_ok_next     = freq_ok_reg;
        clk_lost_next    = clk_lost_reg;
        lock_drop        = 1'b0;
        irq_set          = 1'b0;

        if (!enable) begin
            state_next       = IDLE;
            win_cnt_next     = '0;
            edge_cnt_next    = '0;
            stall_cnt_next   = '0;
            good_streak_next = '0;
            freq_ok_next     = 1'b0;
            clk_lost_next    = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    win_cnt_next   = '0;
                    edge_cnt_next  = '0;
                    stall_cnt_next = '0;
                    state_next     = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    win_cnt_next   = '0;
                    edge_cnt_next  = '0;
                    stall_cnt_next = '0;
                    if (lock_sync) begin
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (!lock_sync) begin
                        lock_drop = 1'b1;
                    end else begin
                        if (mon_edge && (edge_cnt_reg != 16'hFFFF)) begin
                            edge_cnt_next = edge_cnt_reg + 16'd1;
                        end
                        if (mon_edge) begin
                            stall_cnt_next = '0;
                        end else if (stall_cnt_reg != STALL_MAX) begin
                            stall_cnt_next = stall_cnt_reg + STALL_ONE;
                        end
                        if (win_cnt_reg == WIN_LAST) begin
                            state_next = EVAL;
                        end else begin
                            win_cnt_next = win_cnt_reg + WIN_ONE;
                        end
                    end
                end
                EVAL: begin
                    // Edges seen here are deliberately dropped; the stall count holds.
                    if (!lock_sync) begin
                        lock_drop = 1'b1;
                    end else begin
                        edge_count_next  = edge_cnt_reg;
                        count_valid_next = 1'b1;
                        if (in_tol) begin
                            if (good_streak_reg != GOOD4) begin
                                good_streak_next = good_streak_reg + 4'd1;
                            end
                            if (good_streak_next == GOOD4) begin
                                freq_ok_next = 1'b1;
                            end
                        end else begin
                            irq_set          = freq_ok_reg;
                            good_streak_next = '0;
                            freq_ok_next     = 1'b0;
                        end
                        state_next    = MEASURE;
                        win_cnt_next  = '0;
                        edge_cnt_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase

            if (lock_drop) begin
                state_next       = WAIT_LOCK;
                win_cnt_next     = '0;
                edge_cnt_next    = '0;
                stall_cnt_next   = '0;
                count_valid_next = 1'b0;
                edge_count_next  = edge_count_reg;
                good_streak_next = '0;
                freq_ok_next     = 1'b0;
                irq_set          = freq_ok_reg;
            end

            clk_lost_next = (stall_cnt_next == STALL_MAX);
            if (clk_lost_next && !clk_lost_reg) begin
                good_streak_next = '0;
                freq_ok_next     = 1'b0;
                irq_set          = irq_set | freq_ok_reg;
            end
        end

        // A fault set in the same cycle as irq_clear takes precedence.
        irq_next = irq_set ? 1'b1 : (irq_clear ? 1'b0 : irq_reg);
    end

    assign edge_count  = edge_count_reg;
    assign count_valid = count_valid_reg;
    assign freq_ok     = freq_ok_reg;
    assign clk_lost    = clk_lost_reg;
    assign irq         = irq_reg;

endmodule

// File: tb/tb_audio_clk_monitor.sv
// Randomized bench for audio_clk_monitor: a logged mon_clk generator feeds a
// window-level model of counts, qualification streak and fault flags.
module tb_audio_clk_monitor;

    localparam int W    = 100;
    localparam int E    = 25;
    localparam int T    = 1;
    localparam int G    = 3;
    localparam int S    = 16;
    localparam int NLOG = 16384;

    logic        clk;
    logic        reset_n;
    logic        mon_clk;
    logic        pll_locked;
    logic        enable;
    logic        irq_clear;
    logic [15:0] edge_count;
    logic        count_valid;
    logic        freq_ok;
    logic        clk_lost;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit rise_log [NLOG];
    int mon_period = 4;
    int mon_ph     = 0;
    int last_rise  = -1;

    int m_ms     = 0;
    int m_streak = 0;
    int m_last   = 0;
    bit m_ok     = 1'b0;
    bit m_irq    = 1'b0;

    audio_clk_monitor #(
        .WINDOW_CYCLES (W),
        .EXPECTED_COUNT(E),
        .TOLERANCE     (T),
        .GOOD_WINDOWS  (G),
        .STALL_CYCLES  (S)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mon_clk    (mon_clk),
        .pll_locked (pll_locked),
        .enable     (enable),
        .irq_clear  (irq_clear),
        .edge_count (edge_count),
        .count_valid(count_valid),
        .freq_ok    (freq_ok),
        .clk_lost   (clk_lost),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter and mon_clk pattern; every rising transition is logged by cycle.
    initial begin
        bit prev;
        mon_clk = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            prev = mon_clk;
            if (mon_period == 0) begin
                mon_clk = 1'b0;
            end else begin
                mon_clk = (mon_ph < mon_period / 2);
                mon_ph  = (mon_ph + 1) % mon_period;
            end
            if (mon_clk && !prev) begin
                if (cyc < NLOG) rise_log[cyc] = 1'b1;
                last_rise = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) next_cycle();
    endtask

    task automatic wait_cv(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (count_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_lost(input bit level, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (clk_lost == level) begin
                at = cyc;
                break;
            end
        end
    endtask

    // A rise driven in cycle r is detected in cycle r+2; a window measures 100 cycles from ms.
    function automatic int model_count(input int ms);
        int n = 0;
        for (int c = ms - 2; c <= ms + W - 3; c++) begin
            if (c >= 0 && c < NLOG && rise_log[c]) n++;
        end
        return n;
    endfunction

    task automatic model_fault();
        if (m_ok) m_irq = 1'b1;
        m_ok     = 1'b0;
        m_streak = 0;
    endtask

    task automatic expect_window();
        int at;
        int c;
        wait_cv(250, at);
        check("cv_time", at, m_ms + W + 1);
        c = model_count(m_ms);
        check("edge_count", int'(edge_count), c);
        if (c >= E - T && c <= E + T) begin
            if (m_streak < G) m_streak++;
            if (m_streak == G) m_ok = 1'b1;
        end else begin
            model_fault();
        end
        m_last = c;
        check("freq_ok", int'(freq_ok), int'(m_ok));
        check("irq", int'(irq), int'(m_irq));
        $display("window start=%0d pulse=%0d count=%0d freq_ok=%0b irq=%0b", m_ms, at, edge_count, freq_ok, irq);
        m_ms += W + 1;
    endtask

    task automatic pulse_irq_clear();
        next_cycle();
        irq_clear = 1'b1;
        next_cycle();
        irq_clear = 1'b0;
        @(negedge clk);
        m_irq = 1'b0;
        check("irq_clear", int'(irq), int'(m_irq));
        $display("irq_clear at %0d irq=%0b", cyc, irq);
    endtask

    initial begin
        int at;
        int d;
        int q;
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        enable     = 1'b0;
        irq_clear  = 1'b0;
        mon_ph     = $urandom_range(0, 3);

        wait_cycles(4);
        @(negedge clk);
        check("rst_edge_count", int'(edge_count), 0);
        check("rst_count_valid", int'(count_valid), 0);
        check("rst_freq_ok", int'(freq_ok), 0);
        check("rst_clk_lost", int'(clk_lost), 0);
        check("rst_irq", int'(irq), 0);
        next_cycle();
        reset_n = 1'b1;
        wait_cycles(5 + $urandom_range(0, 7));

        // Nominal period 4: qualifies on the third window.
        enable = 1'b1;
        m_ms   = cyc + 2;
        repeat (4) expect_window();
        check("qualified", int'(freq_ok), 1);

        // Period 5 gives 20 edges per window.
        next_cycle();
        mon_period = 5;
        mon_ph     = $urandom_range(0, 4);
        repeat (2) expect_window();
        pulse_irq_clear();

        next_cycle();
        mon_period = 4;
        mon_ph     = $urandom_range(0, 3);
        repeat (4) expect_window();

        // Stall: hold mon_clk low, then restart it.
        wait_cycles($urandom_range(4, 40));
        mon_period = 0;
        wait_lost(1'b1, 60, at);
        check("lost_time", at, last_rise + S + 3);
        model_fault();
        check("lost_freq_ok", int'(freq_ok), int'(m_ok));
        check("lost_irq", int'(irq), int'(m_irq));
        $display("clk_lost set at %0d last rise %0d", at, last_rise);
        next_cycle();
        mon_period = 4;
        mon_ph     = 0;
        q          = cyc;
        wait_lost(1'b0, 10, at);
        check("lost_clear", at, q + 3);
        repeat (4) expect_window();
        pulse_irq_clear();

        // Lock loss with irq_clear landing on the same cycle as the fault set.
        wait_cycles($urandom_range(5, 80));
        pll_locked = 1'b0;
        d          = cyc;
        wait_cycles(2);
        irq_clear = 1'b1;
        @(negedge clk);
        check("lock_ok_hold", int'(freq_ok), int'(m_ok));
        next_cycle();
        irq_clear = 1'b0;
        model_fault();
        @(negedge clk);
        check("lock_freq_ok", int'(freq_ok), int'(m_ok));
        check("lock_irq_set_wins", int'(irq), int'(m_irq));
        $display("lock drop at %0d freq_ok=%0b irq=%0b", d, freq_ok, irq);
        while (cyc < d + 10) next_cycle();
        pll_locked = 1'b1;
        m_ms       = d + 13;
        expect_window();
        pulse_irq_clear();
        repeat (3) expect_window();

        // Disable mid-window: flags drop, edge_count and irq hold.
        wait_cycles($urandom_range(5, 80));
        enable = 1'b0;
        next_cycle();
        m_ok     = 1'b0;
        m_streak = 0;
        @(negedge clk);
        check("dis_freq_ok", int'(freq_ok), int'(m_ok));
        check("dis_clk_lost", int'(clk_lost), 0);
        check("dis_edge_count", int'(edge_count), m_last);
        check("dis_irq", int'(irq), int'(m_irq));
        $display("disable at %0d edge_count=%0d", cyc, edge_count);
        wait_cycles($urandom_range(3, 10));
        enable = 1'b1;
        m_ms   = cyc + 2;
        repeat (3) expect_window();

        // Reset at window cycle 50 discards the partial window.
        while (cyc < m_ms + 50) next_cycle();
        reset_n = 1'b0;
        next_cycle();
        @(negedge clk);
        check("mid_rst_edge_count", int'(edge_count), 0);
        check("mid_rst_count_valid", int'(count_valid), 0);
        check("mid_rst_freq_ok", int'(freq_ok), 0);
        check("mid_rst_clk_lost", int'(clk_lost), 0);
        check("mid_rst_irq", int'(irq), 0);
        $display("mid-window reset at %0d", cyc);
        wait_cycles(2);
        reset_n  = 1'b1;
        m_ms     = cyc + 3;
        m_ok     = 1'b0;
        m_streak = 0;
        m_irq    = 1'b0;
        m_last   = 0;
        expect_window();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
